// File: rtl/mac_accumulator.sv
// Saturating signed accumulator: sums FRAME_LEN products per frame and presents each
// frame result through a valid/ready handshake.
module mac_accumulator #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [2*WIDTH-1:0]   prod,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [2*WIDTH-1:0]   acc_out,
  output logic                 sat,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [0:0] {StAccum, StOutput} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [PW:0] sum;
  logic [PW-1:0]      sum_clamped;
  logic               sum_ovf;
  logic               accept;
  logic               last;

  // Sign-extended add one bit wider than the product so overflow is visible in the top bits.
  assign sum         = $signed({acc_q[PW-1], acc_q}) + $signed({prod[PW-1], prod});
  assign sum_ovf     = sum[PW] != sum[PW-1];
  assign sum_clamped = !sum_ovf ? sum[PW-1:0] :
                       (sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}});

  assign accept = (state_q == StAccum) && prod_valid;
  assign last   = cnt_q == CNT_W'(FRAME_LEN - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StAccum;
    end else begin
      unique case (state_q)
        StAccum:  if (accept && last) state_d = StOutput;
        StOutput: if (acc_ready) state_d = StAccum;
        default:  state_d = StAccum;
      endcase
    end
  end

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    cnt_d = cnt_q;
    if (clear || (state_q == StOutput && acc_ready)) begin
      acc_d = '0;
      sat_d = 1'b0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = sum_clamped;
      sat_d = sat_q | sum_ovf;
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    prod_ready = 1'b0;
    acc_valid  = 1'b0;
    unique case (state_q)
      StAccum:  prod_ready = 1'b1;
      StOutput: acc_valid  = 1'b1;
      default:  prod_ready = 1'b0;
    endcase
  end

  assign acc_out = acc_q;
  assign sat     = sat_q;
  assign count   = cnt_q;

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage for the sequential 32-bit signed multipliers (booth / radix-4 booth).
- Consumes one signed 2*WIDTH product per handshake and accumulates a frame of FRAME_LEN products into a saturating signed sum.
- Presents each frame result through a valid/ready output handshake.
- Used to build dot-product / FIR-style accumulation on top of the multiplier.

Parameters:
- WIDTH, 32, multiplier operand width; product width is 2*WIDTH.
- FRAME_LEN, 8, number of products summed per output result (≥1).
- CNT_W, 4, width of the product counter; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (0 = reset).
- clear  input  1  synchronous frame abort; discards the partial sum.
- prod_valid  input  1  product present on prod.
- prod_ready  output  1  block accepts prod this cycle.
- prod  input  2*WIDTH  signed product from the multiplier.
- acc_valid  output  1  frame result available.
- acc_ready  input  1  consumer takes the result.
- acc_out  output  2*WIDTH  signed frame sum (saturated).
- sat  output  1  sticky: saturation occurred in the presented frame.
- count  output  CNT_W  products accepted in the current frame.

Behaviour:
- One clock domain. All registers update on the rising edge of clk.
- Reset (rst=0 at an edge) sets the following:
  - state=ACCUM, acc_out=0, sat=0, count=0, acc_valid=0.
  - prod_ready becomes 1 on the first cycle after reset deasserts.
- Reset mid-frame or mid-output discards everything; no result is emitted.
- FSM has two states:
  - ACCUM: prod_ready=1, acc_valid=0.
  - OUTPUT: prod_ready=0, acc_valid=1; acc_out and sat are held stable.
- ACCUM, on an edge with prod_valid=1 (a product is accepted):
  - Compute the sum as acc_out + prod at 2*WIDTH+1 bits.
  - If sum > 2^(2*WIDTH-1)-1: acc_out = max positive, sat=1.
  - If sum < -2^(2*WIDTH-1): acc_out = min negative, sat=1.
  - Otherwise acc_out = sum.
  - count increments.
  - If this accepted product is the FRAME_LEN-th: next state is OUTPUT and count=0.
  - Result latency: acc_valid rises the cycle after the last product is accepted.
- ACCUM with prod_valid=0: all state held. Gaps between products of any length are allowed.
- OUTPUT:
  - Remains in OUTPUT while acc_ready=0. A product offered now is not consumed; the producer must hold it.
  - An edge with acc_ready=1 completes the transfer: next state ACCUM, acc_out=0, sat=0, count=0.
  - The block can accept the next frame's first product on the cycle after the transfer. There is no same-cycle bypass.
- Saturation is clamp-and-continue:
  - Later products keep accumulating from the clamped value, so a frame may leave saturation.
  - sat stays 1 until the frame is transferred.
- clear=1 at an edge:
  - Resets acc_out, sat and count to 0 and forces ACCUM.
  - A product offered in the same cycle is dropped; the handshake is not considered complete.
  - clear in OUTPUT drops the pending result.
  - rst has priority over clear.
- FRAME_LEN=1: every accepted product is passed through to OUTPUT unchanged (no saturation possible).
- count never reaches FRAME_LEN as a visible value; it wraps to 0 on frame completion.
- Throughput: FRAME_LEN accepting cycles plus at least 1 OUTPUT cycle per frame.

Test Plan:
- Basic frame: reset, then feed products -384, 75, 204, 1500, 0, 12, -864, 260 back-to-back with acc_ready=1.
  - prod_ready=0 for one cycle.
  - acc_valid pulses one cycle after the 8th product with acc_out=803, sat=0.
  - Next frame starts from 0.
- Backpressure:
  - Same stream with acc_ready=0 for 5 cycles: acc_out stays at 803 and prod_ready stays 0 throughout.
  - Then acc_ready=1: one transfer, no duplicate acc_valid.
- Gapped input: same products with prod_valid toggling (1 on, 2 off) → identical result 803; count reads 0..7 at the matching points.
- Saturation with WIDTH=32: feed (-2^31)*(-2^31)=2^62 three times, then -2^62, then four zeros.
  - After the 2nd product acc_out clamps to 2^63-1.
  - Final acc_out = 2^63-1 - 2^62 + 2^62 clamped = 2^63-1 … then -2^62 yields 2^62-1.
  - sat=1 on output.
- Clear: after 3 products (12, 5, -51), assert clear together with prod_valid and prod=100.
  - count=0 and 100 is not accepted.
  - Then 8 products of 1 → acc_out=8, sat=0.
- Reset mid-operation:
  - rst=0 during OUTPUT (acc_valid=1) → next cycle acc_valid=0, acc_out=0, count=0.
  - Reset held for 3 edges; after release, accepting 8 products of -1 gives acc_out=-8.
